// File: rtl/emi_arbiter_pkg.sv
// Shared definitions for the EMI arbiter: FSM state encodings, owner codes, request bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package emi_arbiter_pkg;

    // FSM state encodings shared by the arbiter and anything decoding its state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GNT_IF = 2'b01,
        ST_GNT_LS = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Owner codes presented on the owner output
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IF   = 2'b01;
    localparam logic [1:0] OWNER_LS   = 2'b10;

    // Bit positions of each requester inside the request / winner vectors
    localparam int REQ_IF = 0;
    localparam int REQ_LS = 1;

    // Owner code implied by an FSM state; only the grant states own the bus
    function automatic logic [1:0] owner_of(input state_t s);
        logic [1:0] o;
        o = OWNER_NONE;
        case (s)
            ST_GNT_IF: o = OWNER_IF;
            ST_GNT_LS: o = OWNER_LS;
            default:   o = OWNER_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/emi_arb_pick.sv
// Winner selection between the IF and LS requesters; one-hot result, purely combinational.
// Latency: 0 cycles. Optional round-robin via EMI_ARB_ROUND_ROBIN_EN, else LS has fixed priority.
// Backpressure: none; the caller decides when the winner is consumed.
module emi_arb_pick
    import emi_arbiter_pkg::*;
(
    input  logic [1:0] i_reqs,      // bit REQ_IF / bit REQ_LS
    input  logic       i_last_ls,   // 1 when LS held the most recent grant
    output logic [1:0] o_winner     // one-hot, zero when nobody requests
);

`ifndef EMI_ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for history
    logic w_unused_last;
    assign w_unused_last = i_last_ls;
`endif

    // Single requester wins outright; contention resolved by pointer or fixed priority
    always_comb begin
        o_winner = 2'b00;
        if (i_reqs[REQ_IF] && i_reqs[REQ_LS]) begin
`ifdef EMI_ARB_ROUND_ROBIN_EN
            if (i_last_ls) o_winner[REQ_IF] = 1'b1;
            else           o_winner[REQ_LS] = 1'b1;
`else
            o_winner[REQ_LS] = 1'b1;
`endif
        end else if (i_reqs[REQ_LS]) begin
            o_winner[REQ_LS] = 1'b1;
        end else if (i_reqs[REQ_IF]) begin
            o_winner[REQ_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/emi_arbiter.sv
// Two-requester (IF read-only, LS read/write) arbiter onto a single EMI request/valid port.
// Latency: emi_req rises 1 cycle after a request is sampled in IDLE; valids are combinational from emi_valid.
// Backpressure: a grant is held with all emi_* stable until emi_valid; EMI_ARB_ROUND_ROBIN_EN selects round-robin.
module emi_arbiter
    import emi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    // IF requester (reads only)
    input  logic [ADDR_W-1:0]   if_address,
    input  logic                if_req,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    // LS requester
    input  logic [ADDR_W-1:0]   ls_address,
    input  logic                ls_req,
    input  logic                ls_rnw,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wbe,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_valid,
    // EMI side
    output logic [ADDR_W-1:0]   emi_address,
    output logic                emi_req,
    output logic                emi_rnw,
    output logic [DATA_W-1:0]   emi_wdata,
    output logic [DATA_W/8-1:0] emi_wbe,
    input  logic [DATA_W-1:0]   emi_rdata,
    input  logic                emi_valid,
    // Current grant
    output logic [1:0]          owner
);

    localparam int BE_W = DATA_W / 8;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        w_winner;
    logic              w_grant;
    logic              w_last_ls;

    logic [ADDR_W-1:0] r_emi_address;
    logic              r_emi_rnw;
    logic [DATA_W-1:0] r_emi_wdata;
    logic [BE_W-1:0]   r_emi_wbe;

    // Requests only matter while IDLE; elsewhere they are ignored entirely
    assign w_grant = (r_state == ST_IDLE) && (w_winner != 2'b00);

`ifdef EMI_ARB_ROUND_ROBIN_EN
    logic r_last_ls;

    // Remember who took the last grant; reset as "LS last" so IF wins first contention
    always_ff @(posedge clk) begin
        if (reset)        r_last_ls <= 1'b1;
        else if (w_grant) r_last_ls <= w_winner[REQ_LS];
    end

    assign w_last_ls = r_last_ls;
`else
    assign w_last_ls = 1'b0;
`endif

    emi_arb_pick u_pick (
        .i_reqs    ({ls_req, if_req}),
        .i_last_ls (w_last_ls),
        .o_winner  (w_winner)
    );

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: grant from IDLE, wait for emi_valid, one DONE cycle, back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_winner[REQ_LS])      w_state_nxt = ST_GNT_LS;
                else if (w_winner[REQ_IF]) w_state_nxt = ST_GNT_IF;
            end
            ST_GNT_IF, ST_GNT_LS: begin
                if (emi_valid) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's command on the grant edge; held untouched until the next grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_emi_address <= '0;
            r_emi_rnw     <= 1'b1;
            r_emi_wdata   <= '0;
            r_emi_wbe     <= '0;
        end else if (w_grant) begin
            if (w_winner[REQ_LS]) begin
                r_emi_address <= ls_address;
                r_emi_rnw     <= ls_rnw;
                r_emi_wdata   <= ls_wdata;
                r_emi_wbe     <= ls_wbe;
            end else begin
                // IF is read-only: no write data or byte enables ever leave for it
                r_emi_address <= if_address;
                r_emi_rnw     <= 1'b1;
                r_emi_wdata   <= '0;
                r_emi_wbe     <= '0;
            end
        end
    end

    assign emi_address = r_emi_address;
    assign emi_rnw     = r_emi_rnw;
    assign emi_wdata   = r_emi_wdata;
    assign emi_wbe     = r_emi_wbe;
    assign emi_req     = (r_state == ST_GNT_IF) || (r_state == ST_GNT_LS);
    assign owner       = owner_of(r_state);

    // Read data is shared; the valids alone tell each requester whether it is theirs
    assign if_rdata = emi_rdata;
    assign ls_rdata = emi_rdata;
    assign if_valid = emi_valid && (r_state == ST_GNT_IF);
    assign ls_valid = emi_valid && (r_state == ST_GNT_LS);

endmodule

// File: tb/tb_emi_arbiter.sv
// Randomised transaction-level bench for emi_arbiter with a rule-based grant model.
// Latency: checks the 1-cycle grant latency and combinational valid/rdata paths.
// Backpressure: emi_valid latency randomised; stability of emi_* checked every wait cycle.
module tb_emi_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_address;
    logic        if_req;
    logic [63:0] if_rdata;
    logic        if_valid;
    logic [31:0] ls_address;
    logic        ls_req;
    logic        ls_rnw;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wbe;
    logic [63:0] ls_rdata;
    logic        ls_valid;
    logic [31:0] emi_address;
    logic        emi_req;
    logic        emi_rnw;
    logic [63:0] emi_wdata;
    logic [7:0]  emi_wbe;
    logic [63:0] emi_rdata;
    logic        emi_valid;
    logic [1:0]  owner;

    int n_vec = 0;
    int n_err = 0;

    // Model history: who received the most recent grant (reset value: LS)
    bit m_last_ls = 1'b1;

    always #5 clk = ~clk;

    emi_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .if_address  (if_address),
        .if_req      (if_req),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .ls_address  (ls_address),
        .ls_req      (ls_req),
        .ls_rnw      (ls_rnw),
        .ls_wdata    (ls_wdata),
        .ls_wbe      (ls_wbe),
        .ls_rdata    (ls_rdata),
        .ls_valid    (ls_valid),
        .emi_address (emi_address),
        .emi_req     (emi_req),
        .emi_rnw     (emi_rnw),
        .emi_wdata   (emi_wdata),
        .emi_wbe     (emi_wbe),
        .emi_rdata   (emi_rdata),
        .emi_valid   (emi_valid),
        .owner       (owner)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant rule: 0 none, 1 IF, 2 LS
    function automatic int model_pick(input bit ir, input bit lr);
        if (ir && lr) begin
`ifdef EMI_ARB_ROUND_ROBIN_EN
            return m_last_ls ? 1 : 2;
`else
            return 2;
`endif
        end
        if (lr) return 2;
        if (ir) return 1;
        return 0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".emi_req"}, 64'(emi_req), 64'd0);
        chk({tag, ".owner"},   64'(owner),   64'd0);
    endtask

    // One transaction starting in IDLE and ending back in IDLE
    task automatic run_txn(input bit ir, input bit lr, input logic [31:0] ia,
                           input logic [31:0] la, input bit lrnw, input logic [63:0] lwd,
                           input logic [7:0] lbe, input int lat, input bit drop);
        int          w;
        logic [31:0] ea;
        logic        ernw;
        logic [63:0] ewd;
        logic [7:0]  ebe;
        logic [63:0] rd;
        if_req     = ir;
        if_address = ia;
        ls_req     = lr;
        ls_address = la;
        ls_rnw     = lrnw;
        ls_wdata   = lwd;
        ls_wbe     = lbe;
        w = model_pick(ir, lr);
        if (w == 0) begin
            // Stray emi_valid while idle must not reach either requester
            emi_valid = 1'b1;
            emi_rdata = {$urandom, $urandom};
            #1;
            chk("stray_idle.if_valid", 64'(if_valid), 64'd0);
            chk("stray_idle.ls_valid", 64'(ls_valid), 64'd0);
            tick();
            emi_valid = 1'b0;
            check_idle_outputs("no_req");
            return;
        end
        m_last_ls = (w == 2);
        if (w == 1) begin
            ea = ia; ernw = 1'b1; ewd = 64'd0; ebe = 8'd0;
        end else begin
            ea = la; ernw = lrnw; ewd = lwd; ebe = lbe;
        end
        tick();
        chk("grant.emi_req", 64'(emi_req),     64'd1);
        chk("grant.owner",   64'(owner),       64'(w));
        chk("grant.addr",    64'(emi_address), 64'(ea));
        chk("grant.rnw",     64'(emi_rnw),     64'(ernw));
        chk("grant.wdata",   emi_wdata,        ewd);
        chk("grant.wbe",     64'(emi_wbe),     64'(ebe));
        for (int c = 0; c < lat; c++) begin
            // Requester inputs wander; the captured command must not
            if_address = $urandom;
            ls_address = $urandom;
            ls_wdata   = {$urandom, $urandom};
            ls_wbe     = 8'($urandom);
            ls_rnw     = 1'($urandom);
            if (drop) begin
                if (w == 1) if_req = 1'b0;
                else        ls_req = 1'b0;
            end
            #1;
            chk("wait.if_valid", 64'(if_valid), 64'd0);
            chk("wait.ls_valid", 64'(ls_valid), 64'd0);
            tick();
            chk("hold.emi_req", 64'(emi_req),     64'd1);
            chk("hold.owner",   64'(owner),       64'(w));
            chk("hold.addr",    64'(emi_address), 64'(ea));
            chk("hold.rnw",     64'(emi_rnw),     64'(ernw));
            chk("hold.wdata",   emi_wdata,        ewd);
            chk("hold.wbe",     64'(emi_wbe),     64'(ebe));
        end
        rd = {$urandom, $urandom};
        emi_valid = 1'b1;
        emi_rdata = rd;
        #1;
        chk("resp.if_valid", 64'(if_valid), 64'(w == 1));
        chk("resp.ls_valid", 64'(ls_valid), 64'(w == 2));
        chk("resp.rdata",    (w == 1) ? if_rdata : ls_rdata, rd);
        tick();
        emi_valid = 1'b0;
        // DONE: bus released, stray valid ignored
        check_idle_outputs("done");
        emi_valid = 1'($urandom);
        #1;
        chk("done.if_valid", 64'(if_valid), 64'd0);
        chk("done.ls_valid", 64'(ls_valid), 64'd0);
        tick();
        emi_valid = 1'b0;
        check_idle_outputs("back_idle");
    endtask

    // Reset while LS owns the bus, then a late emi_valid
    task automatic run_reset_abort();
        if_req     = 1'b0;
        ls_req     = 1'b1;
        ls_address = 32'h0000_0abc;
        ls_rnw     = 1'b0;
        ls_wdata   = 64'h1122_3344_5566_7788;
        ls_wbe     = 8'hff;
        tick();
        chk("abort.owner", 64'(owner), 64'd2);
        tick();
        ls_req = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        m_last_ls = 1'b1;
        check_idle_outputs("abort");
        chk("abort.addr",  64'(emi_address), 64'd0);
        chk("abort.rnw",   64'(emi_rnw),     64'd1);
        chk("abort.wdata", emi_wdata,        64'd0);
        chk("abort.wbe",   64'(emi_wbe),     64'd0);
        emi_valid = 1'b1;
        #1;
        chk("abort.late_ls_valid", 64'(ls_valid), 64'd0);
        chk("abort.late_if_valid", 64'(if_valid), 64'd0);
        tick();
        emi_valid = 1'b0;
        check_idle_outputs("abort.no_replay");
        tick();
        check_idle_outputs("abort.still_idle");
    endtask

    initial begin
        reset      = 1'b1;
        if_address = '0;
        if_req     = 1'b0;
        ls_address = '0;
        ls_req     = 1'b0;
        ls_rnw     = 1'b1;
        ls_wdata   = '0;
        ls_wbe     = '0;
        emi_rdata  = '0;
        emi_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle_outputs("reset");
        chk("reset.rnw",      64'(emi_rnw),     64'd1);
        chk("reset.addr",     64'(emi_address), 64'd0);
        chk("reset.wdata",    emi_wdata,        64'd0);
        chk("reset.wbe",      64'(emi_wbe),     64'd0);
        chk("reset.if_valid", 64'(if_valid),    64'd0);
        chk("reset.ls_valid", 64'(ls_valid),    64'd0);

        // IF-only read, response 3 cycles after emi_req
        run_txn(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 64'd0, 8'd0, 3, 1'b0);
        // LS write with partial byte enables
        run_txn(1'b0, 1'b1, 32'h0, 32'h68, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 8'h0f, 2, 1'b0);
        // Sustained contention: RR alternates starting with IF, fixed gives LS each time
        for (int k = 0; k < 4; k++)
            run_txn(1'b1, 1'b1, 32'h100 + 32'(k), 32'h200 + 32'(k), 1'b1, 64'd0, 8'd0, 1, 1'b0);
        // Stray valid in IDLE, then IF drops req mid-grant
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 64'd0, 8'd0, 0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 64'd0, 8'd0, 3, 1'b1);
        // Reset in the middle of an LS grant
        run_reset_abort();
        // After reset the pointer is back to "LS last"
        run_txn(1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 64'h55, 8'h01, 0, 1'b0);

        for (int t = 0; t < 60; t++)
            run_txn(1'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom),
                    {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
